// File: rtl/exec_div_sequencer_pkg.sv
// Shared execute-stage definitions for the M-extension divide path.
package exec_div_sequencer_pkg;

    // Divide sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } divState_t;

    // funct3 encodings of the RV32M divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Opcode and funct7 that identify M-extension register ops in decode
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // All divide/remainder codes have funct3[2] set; multiplies do not
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/exec_div_sequencer_div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic        [XLEN+1:0] shifted;
    logic signed [XLEN+1:0] diff;
    logic                   neg;

    // Next dividend bit enters the partial remainder from the top of quo
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {2'b00, divisor};
    assign neg     = diff[XLEN+1];

    // Restore on a negative difference, otherwise keep it and record a 1
    always_comb begin
        rem_nxt = neg ? shifted[XLEN:0] : diff[XLEN:0];
        quo_nxt = {quo[XLEN-2:0], ~neg};
    end

endmodule

// File: rtl/exec_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU controller for the execute stage.
module exec_div_sequencer
    import exec_div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            flush,
    input  logic            divReq,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            stall,
    output logic            busy,
    output logic            resultValid,
    output logic [XLEN-1:0] divResult
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    divState_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             sgn_q;      // signed operation
    logic             rsel_q;     // 1: remainder, 0: quotient
    logic             qneg_q;
    logic             rneg_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;        // raw divisor, then its magnitude after INIT
    logic [XLEN-1:0]  quo_q;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  res_q;

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             ovf;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic             accept;
    logic [XLEN:0]    rem_step;
    logic [XLEN-1:0]  quo_step;

    // Two's-complement negation when en is set, wrapping modulo 2^XLEN
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    assign a_s      = a_q;
    assign b_s      = b_q;
    assign sign_a   = sgn_q && (a_s < 0);
    assign sign_b   = sgn_q && (b_s < 0);
    assign mag_a    = cond_neg(a_q, sign_a);
    assign mag_b    = cond_neg(b_q, sign_b);
    assign div_zero = (b_q == '0);
    assign ovf      = sgn_q && (a_q == XMIN) && (b_q == '1);
    assign accept   = (state == IDLE) && divReq && is_div_op(funct3) && !flush;

    assign busy      = (state != IDLE);
    assign divResult = res_q;

    div_iter_step #(.XLEN(XLEN)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (b_q),
        .rem_nxt (rem_step),
        .quo_nxt (quo_step)
    );

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides everything
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        resultValid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = INIT;
                    stall     = 1'b1;
                end
            end
            INIT: begin
                stall     = 1'b1;
                state_nxt = (div_zero || ovf) ? DONE : ITER;
            end
            ITER: begin
                stall = 1'b1;
                if (cnt == '0) state_nxt = FIX;
            end
            FIX: begin
                stall     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                resultValid = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt   = IDLE;
            stall       = 1'b0;
            resultValid = 1'b0;
        end
    end

    // Operand capture, iteration datapath and result register; frozen on flush
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt    <= '0;
            sgn_q  <= 1'b0;
            rsel_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            res_q  <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgn_q  <= ~funct3[0];
                        rsel_q <= funct3[1];
                        a_q    <= srcA;
                        b_q    <= srcB;
                    end
                end
                INIT: begin
                    qneg_q <= sign_a ^ sign_b;
                    rneg_q <= sign_a;
                    if (div_zero) begin
                        quo_q <= '1;
                        rem_q <= {1'b0, a_q};
                        res_q <= rsel_q ? a_q : '1;
                    end else if (ovf) begin
                        quo_q <= XMIN;
                        rem_q <= '0;
                        res_q <= rsel_q ? '0 : XMIN;
                    end else begin
                        rem_q <= '0;
                        quo_q <= mag_a;
                        b_q   <= mag_b;
                        cnt   <= CNT_W'(XLEN - 1);
                    end
                end
                ITER: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    res_q <= rsel_q ? cond_neg(rem_q[XLEN-1:0], rneg_q)
                                    : cond_neg(quo_q, qneg_q);
                end
                default: ;
            endcase
        end
    end

    // The instruction must stay in execute while the divide is running
    a_divreq_held: assert property (@(posedge clk) disable iff (!rstN)
        ((state inside {INIT, ITER, FIX}) && !flush) |-> divReq);

endmodule

// File: tb/tb_exec_div_sequencer.sv
// Directed self-checking bench for exec_div_sequencer.
module tb_exec_div_sequencer;
    import exec_div_sequencer_pkg::*;

    logic        clk    = 1'b0;
    logic        rstN   = 1'b1;
    logic        flush  = 1'b0;
    logic        divReq = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] srcA   = '0;
    logic [31:0] srcB   = '0;
    logic        stall;
    logic        busy;
    logic        resultValid;
    logic [31:0] divResult;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    exec_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .flush       (flush),
        .divReq      (divReq),
        .funct3      (funct3),
        .srcA        (srcA),
        .srcB        (srcB),
        .stall       (stall),
        .busy        (busy),
        .resultValid (resultValid),
        .divResult   (divResult)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide from IDLE and follow it to DONE (bounded wait)
    task automatic run_div(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        int cyc;
        int stalls;
        @(negedge clk);
        divReq = 1'b1; funct3 = f3; srcA = a; srcB = b;
        #1;
        chk({tag, " accept stall"}, 32'(stall), 32'd1);
        stalls = stall ? 1 : 0;
        cyc = 0;
        while (!resultValid && cyc < 60) begin
            @(negedge clk); #1;
            cyc++;
            if (stall) stalls++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " stall cycles"}, 32'(stalls), 32'(lat));
        chk({tag, " valid"}, 32'(resultValid), 32'd1);
        chk({tag, " done stall"}, 32'(stall), 32'd0);
        chk({tag, " result"}, divResult, exp);
        divReq = 1'b0;
    endtask

    initial begin
        // Asynchronous reset
        #2 rstN = 1'b0;
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(resultValid), 32'd0);
        chk("rst result", divResult, 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Unsigned and signed divides
        run_div("DIVU 100/7", F3_DIVU, 32'd100, 32'd7, 32'd14, 35);
        run_div("REMU 100/7", F3_REMU, 32'd100, 32'd7, 32'd2, 35);
        run_div("DIV -100/7", F3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35);
        run_div("REM -100/7", F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35);

        // Result holds with valid low in the idle cycle after DONE
        @(negedge clk); #1;
        chk("hold valid", 32'(resultValid), 32'd0);
        chk("hold result", divResult, 32'hFFFF_FFFE);
        chk("hold busy", 32'(busy), 32'd0);

        // Divide by zero and signed overflow, issued back to back
        run_div("DIV 5/0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_div("REM 5/0", F3_REM, 32'd5, 32'd0, 32'd5, 2);
        run_div("DIV ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_div("REM ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Non-divide funct3 is ignored
        @(negedge clk);
        divReq = 1'b1; funct3 = 3'b000; srcA = 32'd9; srcB = 32'd3;
        #1;
        chk("nondiv stall", 32'(stall), 32'd0);
        @(negedge clk); #1;
        chk("nondiv busy", 32'(busy), 32'd0);
        divReq = 1'b0;

        // Flush at cycle 20 of a divide
        @(negedge clk);
        divReq = 1'b1; funct3 = F3_DIVU; srcA = 32'd1000; srcB = 32'd3;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush valid", 32'(resultValid), 32'd0);
        chk("flush busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0; divReq = 1'b0;
        #1;
        chk("post flush busy", 32'(busy), 32'd0);
        chk("post flush stall", 32'(stall), 32'd0);
        chk("post flush result", divResult, 32'd0);
        run_div("DIVU 9/3", F3_DIVU, 32'd9, 32'd3, 32'd3, 35);

        // Reset pulsed in the middle of ITER
        @(negedge clk);
        divReq = 1'b1; funct3 = F3_DIVU; srcA = 32'd100; srcB = 32'd7;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        #1;
        chk("pre rst busy", 32'(busy), 32'd1);
        #1;
        rstN = 1'b0; divReq = 1'b0;
        #1;
        chk("mid rst stall", 32'(stall), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst valid", 32'(resultValid), 32'd0);
        chk("mid rst result", divResult, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("after rst busy", 32'(busy), 32'd0);
            chk("after rst valid", 32'(resultValid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exec_div_sequencer.md
# exec_div_sequencer

Multi-cycle integer divide controller for the execute stage. It implements RV32M DIV/DIVU/REM/REMU. When a divide reaches execute, the block captures the forwarded operands, stalls the front of the pipeline and runs a radix-2 restoring divider for 32 iterations. It then presents the corrected quotient or remainder for one cycle so the execute result mux can select it in place of the ALU result.

## Interface
Parameters:
- XLEN, 32, operand and result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  asynchronous active-low reset
- flush  in  1  execute-stage flush; aborts any operation in progress
- divReq  in  1  divide instruction currently valid in execute (held while stalled)
- funct3  in  3  3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; other codes are ignored
- srcA  in  XLEN  dividend, post-forwarding
- srcB  in  XLEN  divisor, post-forwarding
- stall  out  1  hold fetch/decode/execute pipeline registers
- busy  out  1  state is not IDLE
- resultValid  out  1  divResult is valid this cycle
- divResult  out  XLEN  quotient or remainder

## Operation
- Accept condition: state IDLE, divReq=1, funct3[2]=1, flush=0. On acceptance, capture op type, signed flag (funct3[0]=0), result select (funct3[1]), srcA, srcB.
- IDLE: stall = accept condition (combinational). Next state is INIT on accept, else IDLE.
- INIT: convert signed operands to magnitudes and record the quotient sign (signA^signB) and remainder sign (signA).
  - Divide by zero (srcB=0): go to DONE with quotient all ones and remainder = srcA, with no sign correction applied.
  - Signed overflow (srcA=0x80000000, srcB=0xFFFFFFFF, signed): go to DONE with quotient 0x80000000 and remainder 0.
  - Otherwise clear the remainder register, load the dividend into the quotient register, set count = XLEN-1, go to ITER.
- ITER: per cycle, shift {rem,quo} left by 1 and trial-subtract the divisor from the (XLEN+1)-bit remainder. If the difference is non-negative, keep it and set quo[0]=1; else restore and set quo[0]=0. When count==0 go to FIX, else decrement.
- FIX: negate the quotient if its sign is set, negate the remainder if its sign is set. Go to DONE.
- DONE: resultValid=1, stall=0, divResult = remainder if result select else quotient. Unconditionally go to IDLE; the pipeline advances on this edge.
- stall=1 in INIT, ITER and FIX, and in IDLE on accept. stall=0 in DONE.
- flush has highest priority:
  - In any state, stall=0 and resultValid=0 in the flush cycle.
  - Next state is IDLE and no result is produced.
- divReq deasserting mid-operation (outside flush) is illegal; it is checked by assertion only.
- Non-divide funct3 with divReq=1 in IDLE: no accept, stall=0.
- Arithmetic: remainder datapath is XLEN+1 bits. Negation is two's complement, modulo 2^XLEN.

## Timing
- Reset (rstN low, asynchronous): state IDLE, count 0, all datapath registers 0, stall 0, busy 0, resultValid 0, divResult 0.
- Normal divide: accept at cycle 0, INIT at cycle 1, ITER at cycles 2..33, FIX at cycle 34, DONE at cycle 35 with resultValid=1.
  - Total stall = 35 cycles (cycles 0..34). Latency from accept to result = 35 cycles.
- Divide by zero or overflow: accept at cycle 0, INIT at cycle 1, DONE at cycle 2. Stall lasts 2 cycles.
- Back-to-back divides: a second divReq in the cycle after DONE is accepted from IDLE with no bubble beyond that idle cycle.
- Reset asserted mid-ITER: outputs clear immediately (asynchronous). Operation restarts only on a fresh accept after reset release.
- divResult holds its last value outside DONE; only resultValid qualifies it.

## Structure
- The shared core package holds:
  - enum divState_t {IDLE, INIT, ITER, FIX, DONE}
  - localparams for the funct3 codes DIV/DIVU/REM/REMU
  - the M-extension opcode constants used by decode
- One sub-module, div_iter_step: a combinational single restoring step with inputs {rem, quo, divisor} and outputs {rem', quo'}. The FSM, counter and sign fix-up stay in exec_div_sequencer.

## Test plan
- DIVU 100/7 → stall high for 35 cycles, resultValid at cycle 35, divResult=14. REMU with the same operands gives 2.
- DIV -100/7 → quotient 0xFFFFFFF2 (-14). REM -100/7 → 0xFFFFFFFE (-2), with the remainder sign following the dividend.
- DIV 5/0 → DONE at cycle 2, result 0xFFFFFFFF. REM 5/0 → result 5.
- DIV 0x80000000/0xFFFFFFFF → result 0x80000000. REM with the same operands → 0. Both take a 2-cycle stall.
- flush at cycle 20 of a divide → stall=0 and resultValid=0 that cycle, busy=0 next cycle. A following DIVU 9/3 accepted afterwards returns 3.
- rstN pulsed low during ITER → stall, busy and resultValid go to 0 without waiting for clk. With divReq low after release, nothing happens.
